// File: rtl/fp_pkg.sv
// fp_pkg: definitions shared by the floating-point datapath blocks.
//   - FLG_* : bit positions within the 4-bit exception flag vector
//   - fp_cls_e : operand classification produced in the first stage
//   - fp_qnan() : canonical quiet NaN, returned right-aligned in 128 bits
package fp_pkg;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_e;

    // {0, all-ones exponent, 1, zeros}. Callers truncate to their word width.
    function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = (((128'd1 << exp_w) - 128'd1) << man_w) | (128'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational normalise / round-to-nearest-even / special-case
// resolution / packing for a raw significand product.
//   sign_i   : result sign
//   cls_a_i  : class of operand A (fp_cls_e encoding)
//   cls_b_i  : class of operand B
//   esum_i   : signed biased exponent before normalisation (EXP_W+2 bits)
//   prod_i   : unsigned significand product, binary point below bit PW-2
//   p_o      : packed result {sign, exponent, fraction}
//   flags_o  : {invalid, overflow, underflow, inexact}
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   sign_i,
    input  logic [1:0]             cls_a_i,
    input  logic [1:0]             cls_b_i,
    input  logic [EXP_W+1:0]       esum_i,
    input  logic [2*MAN_W+1:0]     prod_i,
    output logic [EXP_W+MAN_W:0]   p_o,
    output logic [3:0]             flags_o
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'((1 << EXP_W) - 1);

    logic                    msb;
    logic [PW-2:0]           norm;       // product below the hidden bit, left-aligned
    logic [MAN_W-1:0]        frac;
    logic                    g_bit, s_bit, rnd_up, carry;
    logic [MAN_W-1:0]        frac_r;
    logic signed [EXP_W+1:0] esum_n, esum_f;
    logic                    any_nan, any_inf, any_zero, inv, ovf, unf;

    always_comb begin
        msb  = prod_i[PW-1];
        // Drop the hidden bit; the shift-in zero never affects the sticky OR.
        norm = msb ? prod_i[PW-2:0] : {prod_i[PW-3:0], 1'b0};
        frac  = norm[PW-2 -: MAN_W];
        g_bit = norm[MAN_W];
        s_bit = |norm[MAN_W-1:0];
        rnd_up = g_bit & (s_bit | frac[0]);
        // All-ones fraction rounding up wraps frac_r to zero by itself.
        {carry, frac_r} = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
        esum_n = $signed(esum_i) + $signed({{(EXP_W+1){1'b0}}, msb});
        esum_f = esum_n + $signed({{(EXP_W+1){1'b0}}, carry});

        any_nan  = (cls_a_i == CLS_NAN)  | (cls_b_i == CLS_NAN);
        any_inf  = (cls_a_i == CLS_INF)  | (cls_b_i == CLS_INF);
        any_zero = (cls_a_i == CLS_ZERO) | (cls_b_i == CLS_ZERO);
        inv = any_inf & any_zero;
        ovf = (esum_f >= EMAX_S);
        unf = esum_f[EXP_W+1] | (esum_f == '0);

        p_o     = {sign_i, esum_f[EXP_W-1:0], frac_r};
        flags_o = 4'b0000;
        flags_o[FLG_INX] = g_bit | s_bit;

        if (any_nan | inv) begin
            p_o     = QNAN;
            flags_o = 4'b0000;
            flags_o[FLG_INV] = inv;
        end else if (any_inf) begin
            p_o     = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_o = 4'b0000;
        end else if (any_zero) begin
            p_o     = {sign_i, {(W-1){1'b0}}};
            flags_o = 4'b0000;
        end else if (ovf) begin
            p_o     = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_o = 4'b0000;
            flags_o[FLG_OVF] = 1'b1;
            flags_o[FLG_INX] = 1'b1;
        end else if (unf) begin
            p_o     = {sign_i, {(W-1){1'b0}}};
            flags_o = 4'b0000;
            flags_o[FLG_UNF] = 1'b1;
            flags_o[FLG_INX] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier with valid/ready.
//   S1 classify + exponent sum, S2 significand multiply, S3 round/pack into
//   the output register. All stages advance together when the output slot is
//   empty or being drained; bubbles are carried, not compressed.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_a, in_b operands
//   out_valid/out_ready : result handshake; out_p product, out_flags
//                         {invalid, overflow, underflow, inexact}
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_p,
    output logic [3:0]           out_flags
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int PW     = 2 * MAN_W + 2;
    localparam int STAGES = 3;
    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);

    // Stage valid bits: [1]=S1, [2]=S2, [3]=output register.
    logic [STAGES:1] vld_pipe_q, vld_pipe_d;
    logic            adv;

    // S1
    logic                    s1_sign_q, s1_sign_d;
    fp_cls_e                 s1_cls_a_q, s1_cls_a_d, s1_cls_b_q, s1_cls_b_d;
    logic signed [EXP_W+1:0] s1_esum_q, s1_esum_d;
    logic [MAN_W:0]          s1_ma_q, s1_ma_d, s1_mb_q, s1_mb_d;
    // S2
    logic                    s2_sign_q, s2_sign_d;
    fp_cls_e                 s2_cls_a_q, s2_cls_a_d, s2_cls_b_q, s2_cls_b_d;
    logic signed [EXP_W+1:0] s2_esum_q, s2_esum_d;
    logic [PW-1:0]           s2_prod_q, s2_prod_d;
    // S3 / output
    logic [W-1:0]            p_q, p_d, rp_p;
    logic [3:0]              flags_q, flags_d, rp_flags;

    function automatic fp_cls_e classify(input logic [W-1:0] x);
        if (x[W-2 -: EXP_W] == '0)                 return CLS_ZERO; // subnormals flush
        else if (x[W-2 -: EXP_W] != '1)            return CLS_NORM;
        else if (x[MAN_W-1:0] == '0)               return CLS_INF;
        else                                       return CLS_NAN;
    endfunction

    assign adv       = ~vld_pipe_q[STAGES] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe_q[STAGES];
    assign out_p     = p_q;
    assign out_flags = flags_q;

    fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
        .sign_i  (s2_sign_q),
        .cls_a_i (s2_cls_a_q),
        .cls_b_i (s2_cls_b_q),
        .esum_i  (s2_esum_q),
        .prod_i  (s2_prod_q),
        .p_o     (rp_p),
        .flags_o (rp_flags)
    );

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_sign_d = s1_sign_q;  s1_cls_a_d = s1_cls_a_q;  s1_cls_b_d = s1_cls_b_q;
        s1_esum_d = s1_esum_q;  s1_ma_d    = s1_ma_q;     s1_mb_d    = s1_mb_q;
        s2_sign_d = s2_sign_q;  s2_cls_a_d = s2_cls_a_q;  s2_cls_b_d = s2_cls_b_q;
        s2_esum_d = s2_esum_q;  s2_prod_d  = s2_prod_q;
        p_d       = p_q;        flags_d    = flags_q;

        if (adv) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
            // Payloads only load behind a valid token so a bubble leaves
            // the previous result visible on out_p.
            if (in_valid) begin
                s1_sign_d  = in_a[W-1] ^ in_b[W-1];
                s1_cls_a_d = classify(in_a);
                s1_cls_b_d = classify(in_b);
                s1_esum_d  = $signed({2'b00, in_a[W-2 -: EXP_W]})
                           + $signed({2'b00, in_b[W-2 -: EXP_W]}) - BIAS_S;
                s1_ma_d    = {1'b1, in_a[MAN_W-1:0]};
                s1_mb_d    = {1'b1, in_b[MAN_W-1:0]};
            end
            if (vld_pipe_q[1]) begin
                s2_sign_d  = s1_sign_q;
                s2_cls_a_d = s1_cls_a_q;
                s2_cls_b_d = s1_cls_b_q;
                s2_esum_d  = s1_esum_q;
                s2_prod_d  = PW'(s1_ma_q) * PW'(s1_mb_q);
            end
            if (vld_pipe_q[2]) begin
                p_d     = rp_p;
                flags_d = rp_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            p_q        <= '0;
            flags_q    <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            p_q        <= p_d;
            flags_q    <= flags_d;
        end
    end

    // Datapath payload carries no reset; validity is tracked by vld_pipe_q.
    always_ff @(posedge clk) begin
        s1_sign_q  <= s1_sign_d;
        s1_cls_a_q <= s1_cls_a_d;
        s1_cls_b_q <= s1_cls_b_d;
        s1_esum_q  <= s1_esum_d;
        s1_ma_q    <= s1_ma_d;
        s1_mb_q    <= s1_mb_d;
        s2_sign_q  <= s2_sign_d;
        s2_cls_a_q <= s2_cls_a_d;
        s2_cls_b_q <= s2_cls_b_d;
        s2_esum_q  <= s2_esum_d;
        s2_prod_q  <= s2_prod_d;
    end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier.
- Successor to the team's combinational binary32 multiplier. Adds:
  - generic exponent/mantissa widths
  - round-to-nearest-even
  - special-value handling
  - exception flags
  - a 3-stage pipeline with valid/ready flow control
- Sits between operand-issue logic and the FP result bus; binary32 is the default configuration.

Parameters:
- EXP_W, 8, exponent field width (>=3).
- MAN_W, 23, stored fraction width (>=2); total word W = 1+EXP_W+MAN_W (localparam); BIAS = 2^(EXP_W-1)-1 (localparam).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  W  operand A {sign, exponent, fraction}.
- in_b  input  W  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result this cycle.
- out_p  output  W  product.
- out_flags  output  4  {invalid, overflow, underflow, inexact}, aligned with out_p.

Behaviour:
- Reset:
  - One clk edge with rst_n=0 clears all three stage valid bits.
  - Resets out_p and out_flags to 0.
  - Any in-flight operations are discarded; no output is produced for them.
  - in_ready is 1 in the first cycle after reset.
- Pipeline advance:
  - Global enable adv = ~out_valid | out_ready.
  - in_ready = adv (combinational, no dependence on in_valid).
  - When adv=1, every stage shifts forward, S1 captures (in_valid, in_a, in_b), and bubbles propagate.
  - When adv=0, all stage registers hold.
  - A transfer occurs on in_valid&in_ready, or on out_valid&out_ready.
- Latency and throughput:
  - Latency is exactly 3 cycles from accept to out_valid when out_ready is held high.
  - Throughput is 1 per cycle; bubbles are not compressed.
- S1 (classify and exponents):
  - Split fields and compute sign = sa^sb.
  - Classify each operand as zero (exp=0; subnormals are flushed to zero, inexact not set), inf, NaN, or normal.
  - esum = ea+eb-BIAS in signed EXP_W+2 bits.
- S2 (multiply):
  - Full (MAN_W+1)x(MAN_W+1) unsigned product with hidden 1s, 2*MAN_W+2 bits.
  - Class and esum are forwarded.
- S3 (normalise, round, pack):
  - If product MSB=1, shift right by 1 and esum+=1.
  - Keep MAN_W fraction bits. G = next bit; S = OR of all lower bits.
  - Round up iff G&(S|LSB) (RNE). inexact = G|S.
  - If rounding carries out of the mantissa, fraction becomes 0 and esum+=1.
- Result priority (first match wins):
  1. Either operand NaN, or inf*zero -> canonical qNaN {0, all-ones exp, 1, zeros}; invalid=1 only for inf*zero.
  2. Either operand inf -> signed inf.
  3. Either operand zero -> signed zero, no flags.
  4. Final esum >= 2^EXP_W-1 -> signed inf; overflow=1, inexact=1.
  5. Final esum <= 0 -> signed zero (no subnormal output); underflow=1, inexact=1.
  6. Otherwise -> normal {sign, esum[EXP_W-1:0], fraction} with inexact as computed.
- Flags are per-result, not sticky.
- Simultaneous out transfer and in accept in the same cycle is legal, and the pipeline stays full.
- out_p and out_flags hold stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package fp_pkg:
  - Flag bit indices (FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_INX=0).
  - Operand class enum {ZERO, NORM, INF, NAN}.
  - Function for canonical qNaN given EXP_W/MAN_W.
- One natural sub-module, fp_round_pack (S3 combinational normalise/round/special-case/pack), so the next adder block can reuse it.

Test Plan:
- Basic, with out_ready=1:
  - 0x3FC00000 * 0x40000000 -> 0x40400000, flags 0, out_valid exactly 3 cycles after accept.
  - 0xC0000000 * 0x40400000 -> 0xC0C00000.
- RNE:
  - 0x3F800800 * 0x3F800800 (exact tie) -> 0x3F801000, flags 0001.
  - 0x3F800001 * 0x3F800001 -> 0x3F800002, flags 0001.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000, flags 1000.
  - 0xFF800000 * 0x40000000 -> 0xFF800000, flags 0000.
  - 0x7FC00001 * 0x3F800000 -> 0x7FC00000, flags 0000.
- Range:
  - 0x7F000000 * 0x7F000000 -> 0x7F800000, flags 0101.
  - 0x00800000 * 0x3F000000 -> 0x00000000, flags 0011.
- Backpressure:
  - Stream 8 random pairs with out_ready toggling pseudo-randomly.
  - Outputs must match a reference model in order with no loss or duplication.
  - in_ready must be 0 whenever out_valid=1 and out_ready=0.
  - out_p must stay stable while stalled.
- Reset mid-stream:
  - With 3 ops in flight, assert rst_n=0 for 1 cycle.
  - Next cycle: out_valid=0, out_p=0, in_ready=1.
  - No stale result ever appears afterwards.
